// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
//
// Shared constants and types for the UART baud-rate tick generator.
//   DIV_W       - default width of the divisor and of the cycle counter
//   OVS         - default number of oversample ticks per bit tick
//   FRAC_W      - default width of the fractional accumulator (only used
//                 when the build defines BAUD_FRAC_EN)
//   DEFAULT_DIV - default divisor loaded at reset (period = DEFAULT_DIV + 1)
//   baud_div_t  - divisor type at the default width
//   ovs_cnt_width() - width of the oversample counter, never below 1 bit
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int DIV_W       = 16;
    localparam int OVS         = 16;
    localparam int FRAC_W      = 4;
    localparam int DEFAULT_DIV = 100;

    typedef logic [DIV_W-1:0] baud_div_t;

    // An OVS of 1 still needs a 1-bit counter so the port-free logic
    // below stays well formed; it simply never leaves 0.
    function automatic int ovs_cnt_width(input int ovs);
        return (ovs > 1) ? $clog2(ovs) : 1;
    endfunction

endpackage

// File: rtl/baud_div_reg.sv
// ---------------------------------------------------------------------------
// baud_div_reg
//
// Pending/active divisor register for the baud tick generator. A write
// lands in a pending register; the active divisor is only replaced when
// the counter logic signals an apply event (period boundary or phase
// clear), so the divisor never changes in the middle of a period.
//
// Optional feature: BAUD_FRAC_EN adds a fractional divisor that travels
// alongside the integer divisor through the same pending/apply path.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high
//   apply        in   boundary event: pending divisor becomes active
//   div_wr       in   single-cycle write strobe
//   div_in       in   [DIV_W]  divisor to write
//   frac_in      in   [FRAC_W] fractional divisor (BAUD_FRAC_EN only)
//   frac_cur     out  [FRAC_W] active fractional divisor (BAUD_FRAC_EN only)
//   cur_div      out  [DIV_W]  active divisor
//   div_pending  out  a written divisor has not yet been applied
// ---------------------------------------------------------------------------
module baud_div_reg #(
    parameter int DIV_W       = baud_pkg::DIV_W,
    parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV
`ifdef BAUD_FRAC_EN
    ,
    parameter int FRAC_W      = baud_pkg::FRAC_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              apply,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
    output logic [FRAC_W-1:0] frac_cur,
`endif
    output logic [DIV_W-1:0]  cur_div,
    output logic              div_pending
);

    import baud_pkg::*;

    logic [DIV_W-1:0]  pend_div;
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] pend_frac;
`endif

    // The apply uses the value that was pending before this edge. A write
    // arriving on the same edge as an apply is therefore kept pending for
    // the following boundary instead of slipping straight into cur_div.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_div     <= DIV_W'(DEFAULT_DIV);
            pend_div    <= '0;
            div_pending <= 1'b0;
`ifdef BAUD_FRAC_EN
            frac_cur    <= '0;
            pend_frac   <= '0;
`endif
        end else begin
            if (apply && div_pending) begin
                cur_div  <= pend_div;
`ifdef BAUD_FRAC_EN
                frac_cur <= pend_frac;
`endif
            end
            if (div_wr) begin
                pend_div    <= div_in;
`ifdef BAUD_FRAC_EN
                pend_frac   <= frac_in;
`endif
                div_pending <= 1'b1;
            end else if (apply) begin
                div_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//
// Programmable baud-rate tick generator for the UART TX/RX shift engines.
// A cycle counter runs 0..term and emits a one-cycle oversample tick on the
// terminal count; every OVS oversample ticks a bit tick is emitted together
// with the oversample tick. The divisor can be reloaded at run time (taking
// effect at the next period boundary) and sync_clear re-aligns the phase,
// e.g. on an RX start-bit edge.
//
// Optional feature: BAUD_FRAC_EN adds a fractional divisor. An FRAC_W-bit
// accumulator adds frac_cur at every wrap; a carry stretches the following
// period by one cycle, giving an average period of
// cur_div + 1 + frac_cur / 2^FRAC_W cycles.
//
// Parameters: DIV_W, OVS (>= 1), DEFAULT_DIV, FRAC_W (BAUD_FRAC_EN only)
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high
//   enable       in   low: counters hold, both ticks are 0
//   sync_clear   in   restart tick phase, applies any pending divisor
//   div_wr       in   single-cycle divisor write strobe
//   div_in       in   [DIV_W]  new divisor (period = div_in + 1)
//   frac_in      in   [FRAC_W] fractional divisor (BAUD_FRAC_EN only)
//   ovs_tick     out  oversample tick, one cycle wide
//   bit_tick     out  bit tick, one cycle wide, coincident with ovs_tick
//   div_pending  out  a written divisor has not yet taken effect
//   cur_div      out  [DIV_W]  active divisor
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int DIV_W       = baud_pkg::DIV_W,
    parameter int OVS         = baud_pkg::OVS,
    parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV
`ifdef BAUD_FRAC_EN
    ,
    parameter int FRAC_W      = baud_pkg::FRAC_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_clear,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic              ovs_tick,
    output logic              bit_tick,
    output logic              div_pending,
    output logic [DIV_W-1:0]  cur_div
);

    import baud_pkg::*;

    localparam int OVS_CW = ovs_cnt_width(OVS);
    localparam logic [OVS_CW-1:0] OVS_LAST = OVS_CW'(OVS - 1);

    // With the fractional stretch the terminal count can reach
    // cur_div + 1, so the counter gets one extra bit to hold it.
`ifdef BAUD_FRAC_EN
    localparam int CNT_W = DIV_W + 1;
`else
    localparam int CNT_W = DIV_W;
`endif

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  term;
    logic [OVS_CW-1:0] ovs_cnt;
    logic              wrap;
    logic              apply;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_cur;
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W:0]   acc_sum;
    logic              long_period;

    assign term    = {1'b0, cur_div} + {{DIV_W{1'b0}}, long_period};
    assign acc_sum = {1'b0, frac_acc} + {1'b0, frac_cur};
`else
    assign term = cur_div;
`endif

    // Ticks come only from registered state and enable, never from div_wr.
    assign wrap     = enable && (cnt == term);
    assign ovs_tick = wrap;
    assign bit_tick = wrap && (ovs_cnt == OVS_LAST);

    // The divisor may only change where the counter restarts from 0.
    assign apply = sync_clear || wrap;

    baud_div_reg #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
`ifdef BAUD_FRAC_EN
        ,
        .FRAC_W      (FRAC_W)
`endif
    ) u_div_reg (
        .clk         (clk),
        .reset       (reset),
        .apply       (apply),
        .div_wr      (div_wr),
        .div_in      (div_in),
`ifdef BAUD_FRAC_EN
        .frac_in     (frac_in),
        .frac_cur    (frac_cur),
`endif
        .cur_div     (cur_div),
        .div_pending (div_pending)
    );

    // sync_clear outranks enable so the RX can re-align even while the
    // generator is otherwise paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            ovs_cnt <= '0;
        end else if (sync_clear) begin
            cnt     <= '0;
            ovs_cnt <= '0;
        end else if (!enable) begin
            cnt     <= cnt;
            ovs_cnt <= ovs_cnt;
        end else if (cnt == term) begin
            cnt     <= '0;
            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

`ifdef BAUD_FRAC_EN
    // The carry out of the accumulator at a wrap lengthens only the
    // period that starts at that wrap.
    always_ff @(posedge clk) begin
        if (reset || sync_clear) begin
            frac_acc    <= '0;
            long_period <= 1'b0;
        end else if (wrap) begin
            frac_acc    <= acc_sum[FRAC_W-1:0];
            long_period <= acc_sum[FRAC_W];
        end
    end
`endif

endmodule
